alu_decode_stage: RTL

Pipelined decode stage feeding the ALU. It accepts one 32-bit RV32I instruction per cycle, together with its register-file operands, and decodes it into the ALU's 4-bit `alu_ctrl` code and operand pair. The `a`/`b`/`alu_ctrl` outputs are registered behind a valid/ready handshake with a one-entry skid buffer. It is the producer end of the ALU control interface; the ALU consumes its outputs directly.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_ctrl_lut.sv | 90 +++++++++
 rtl/alu_decode_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU decode path:
//   - 4-bit ALU control codes (AND/OR/ADD/SUB/SLT)
//   - RV32I opcode, funct3 and funct7 values recognised by the decoder
//   - state encoding of the decode stage's output/skid buffer
// No ports; imported with `import alu_pkg::*`.
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALU control codes driven on alu_ctrl
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Major opcodes handled by the ALU
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // funct7 values: base encoding, and the alternate one that turns ADD into SUB
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 values shared by the R-type and I-type forms
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // Occupancy of the output register (O) and skid register (S)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // O and S empty
        ST_ONE   = 2'd1,   // O full, S empty
        ST_TWO   = 2'd2    // O and S full
    } stage_state_t;

endpackage

// File: rtl/alu_ctrl_lut.sv
// ---------------------------------------------------------------------------
// alu_ctrl_lut
// Purely combinational decode of one RV32I instruction into ALU control code
// and operand pair. Unsupported encodings report illegal with all-zero
// outputs.
// Ports:
//   instr    in  XLEN  instruction word
//   rs1      in  XLEN  rs1 register value
//   rs2      in  XLEN  rs2 register value
//   a        out XLEN  ALU operand a (rs1, or 0 if illegal)
//   b        out XLEN  ALU operand b (rs2 / sign-extended imm, or 0 if illegal)
//   alu_ctrl out 4     ALU control code (AND code if illegal)
//   illegal  out 1     instruction not supported by the ALU
// ---------------------------------------------------------------------------
module alu_ctrl_lut
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      alu_ctrl,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            legal;
    logic            use_imm;
    logic [3:0]      code;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // I-type immediate: instr[31] replicated into every bit above bit 11
    assign imm = {{(XLEN-12){instr[31]}}, instr[31:20]};

    // Register specifier fields are resolved upstream; the decoder ignores them
    logic unused_fields;
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    // Only the R-type SUB form may use the alternate funct7; every other
    // R-type operation requires funct7 == 0. I-type ops ignore funct7 since
    // those bits belong to the immediate.
    always_comb begin
        legal   = 1'b0;
        use_imm = 1'b0;
        code    = ALU_AND;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  begin legal = 1'b1; code = ALU_ADD; end
                        F3_AND:  begin legal = 1'b1; code = ALU_AND; end
                        F3_OR:   begin legal = 1'b1; code = ALU_OR;  end
                        F3_SLT:  begin legal = 1'b1; code = ALU_SLT; end
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    legal = 1'b1;
                    code  = ALU_SUB;
                end
            end
            OP_I: begin
                use_imm = 1'b1;
                case (funct3)
                    F3_ADD:  begin legal = 1'b1; code = ALU_ADD; end
                    F3_AND:  begin legal = 1'b1; code = ALU_AND; end
                    F3_OR:   begin legal = 1'b1; code = ALU_OR;  end
                    F3_SLT:  begin legal = 1'b1; code = ALU_SLT; end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal instructions still travel down the pipe, so zero their payload
    assign illegal  = !legal;
    assign alu_ctrl = legal ? code : ALU_AND;
    assign a        = legal ? rs1 : '0;
    assign b        = !legal ? '0 : (use_imm ? imm : rs2);

endmodule

// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
// Registered decode stage in front of the ALU. Each accepted instruction is
// decoded by alu_ctrl_lut and held in an output register; a one-entry skid
// register absorbs the instruction that arrives in the cycle downstream
// stalls, so in_ready can be registered (no out_ready -> in_ready path).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                input handshake (in_ready registered)
//   in_instr, in_rs1, in_rs2         instruction and register operands
//   out_valid/out_ready              output handshake
//   out_a, out_b, out_alu_ctrl       decoded ALU operands and control code
//   out_illegal                      decoded instruction is unsupported
//   illegal_cnt                      saturating count of accepted illegal ops
// ---------------------------------------------------------------------------
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [3:0]       out_alu_ctrl,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    stage_state_t    state;
    stage_state_t    next_state;

    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [3:0]      dec_ctrl;
    logic            dec_illegal;

    logic [XLEN-1:0] skid_a;
    logic [XLEN-1:0] skid_b;
    logic [3:0]      skid_ctrl;
    logic            skid_illegal;

    logic            accept;
    logic            take;

    alu_ctrl_lut #(
        .XLEN (XLEN)
    ) u_lut (
        .instr    (in_instr),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .a        (dec_a),
        .b        (dec_b),
        .alu_ctrl (dec_ctrl),
        .illegal  (dec_illegal)
    );

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    // in_ready is low in ST_TWO, so accept never fires there
    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: if (accept) next_state = ST_ONE;
            ST_ONE: begin
                if (accept && !take)      next_state = ST_TWO;
                else if (!accept && take) next_state = ST_EMPTY;
            end
            ST_TWO:   if (take) next_state = ST_ONE;
            default:  next_state = ST_EMPTY;
        endcase
    end

    // in_ready and out_valid are registered copies of the next occupancy.
    // in_ready resets low and only rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_a        <= '0;
            out_b        <= '0;
            out_alu_ctrl <= ALU_AND;
            out_illegal  <= 1'b0;
            skid_a       <= '0;
            skid_b       <= '0;
            skid_ctrl    <= ALU_AND;
            skid_illegal <= 1'b0;
            illegal_cnt  <= '0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != ST_TWO);
            out_valid <= (next_state != ST_EMPTY);

            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_a        <= dec_a;
                        out_b        <= dec_b;
                        out_alu_ctrl <= dec_ctrl;
                        out_illegal  <= dec_illegal;
                    end
                end
                ST_ONE: begin
                    // O drains this cycle: reload it directly; otherwise park in S
                    if (accept && take) begin
                        out_a        <= dec_a;
                        out_b        <= dec_b;
                        out_alu_ctrl <= dec_ctrl;
                        out_illegal  <= dec_illegal;
                    end else if (accept) begin
                        skid_a       <= dec_a;
                        skid_b       <= dec_b;
                        skid_ctrl    <= dec_ctrl;
                        skid_illegal <= dec_illegal;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        out_a        <= skid_a;
                        out_b        <= skid_b;
                        out_alu_ctrl <= skid_ctrl;
                        out_illegal  <= skid_illegal;
                    end
                end
                default: ;
            endcase

            // Counter sticks at all-ones instead of wrapping
            if (accept && dec_illegal && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule
